l2_plru_cache_ctrl: RTL

- Parameterised write-back, write-allocate controller for the L2 cache, successor to the fixed 8-way L2 control.
- Drives per-way tag/data/valid/dirty array controls, a tree pseudo-LRU (PLRU) state word and the physical-memory handshake for any power-of-two associativity.
- New over the previous generation:
  - an invalid way is filled before a PLRU victim is chosen;
  - the victim is latched at miss time;
  - a flush engine writes back every dirty line on request.

---
 rtl/l2_plru_cache_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/l2_plru_cache_ctrl.sv
// Write-back, write-allocate L2 cache controller with tree pseudo-LRU replacement,
// invalid-way-first victim selection and a whole-cache dirty-line flush engine.
//
// state      | meaning
// PROCESS    | serve hits, decide on misses, accept flush requests
// WRITE_BACK | write the dirty victim line to pmem
// FETCH      | read the requested line from pmem into the victim way
// FLUSH_SCAN | step through every (set, way) looking for dirty lines
// FLUSH_WB   | write back the dirty line under the flush counters
module l2_plru_cache_ctrl #(
    parameter int WAYS     = 8,
    parameter int SET_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    output logic                    mem_resp,
    input  logic [WAYS-1:0]         hit,
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0]         dirty,
    input  logic [WAYS-2:0]         lru_in,
    output logic [WAYS-2:0]         lru_out,
    output logic                    load_lru,
    output logic [WAYS-1:0]         load_tag,
    output logic [WAYS-1:0]         load_data,
    output logic [WAYS-1:0]         load_valid,
    output logic [WAYS-1:0]         load_dirty,
    output logic                    valid_in,
    output logic                    dirty_in,
    output logic                    data_sel,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic                    pmem_addr_sel,
    output logic                    set_override,
    output logic [SET_BITS-1:0]     flush_set,
    output logic                    pmem_read,
    output logic                    pmem_write,
    input  logic                    pmem_resp,
    input  logic                    flush_req,
    output logic                    flush_done
);

    localparam int WB = $clog2(WAYS);
    localparam int LW = WAYS - 1;

    typedef enum logic [2:0] {
        PROCESS    = 3'd0,
        WRITE_BACK = 3'd1,
        FETCH      = 3'd2,
        FLUSH_SCAN = 3'd3,
        FLUSH_WB   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [WB-1:0]         victim, victim_n;
    logic [WB-1:0]         way_cnt, way_n;
    logic [SET_BITS-1:0]   set_cnt, set_n;

    logic                  req_valid;
    logic                  hit_any;
    logic [WB-1:0]         hit_way;
    logic [WB-1:0]         victim_c;
    logic                  flush_last;
    logic                  flush_line_dirty;
    logic [WAYS-1:0]       vd_sh;

    function automatic logic [WB-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAYS-1:0] sh;
        logic [WB-1:0]   idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            sh = v >> i;
            if (sh[0]) idx = WB'(i);
        end
        return idx;
    endfunction

    // Follow the node bits from the root; the final node number minus the
    // internal-node count is the leaf (way) index.
    function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] t);
        logic [WAYS-2:0] sh;
        int              node;
        node = 0;
        for (int l = 0; l < WB; l++) begin
            sh   = t >> node;
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return WB'(node - LW);
    endfunction

    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] t,
                                                    input logic [WB-1:0]   way);
        logic [WAYS-2:0] r;
        logic [WAYS-2:0] mask;
        logic [WB-1:0]   sh;
        int              node;
        r    = t;
        node = 0;
        for (int l = 0; l < WB; l++) begin
            sh   = way >> (WB - 1 - l);
            mask = LW'(1) << node;
            if (sh[0]) r = r & ~mask;
            else       r = r | mask;
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        return r;
    endfunction

    assign req_valid        = mem_read ^ mem_write;
    assign hit_any          = |hit;
    assign hit_way          = lowest_set(hit);
    assign victim_c         = (&valid) ? plru_victim(lru_in) : lowest_set(~valid);
    assign flush_last       = (way_cnt == WB'(WAYS - 1)) && (&set_cnt);
    assign vd_sh            = (valid & dirty) >> way_cnt;
    assign flush_line_dirty = vd_sh[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PROCESS;
            victim  <= '0;
            way_cnt <= '0;
            set_cnt <= '0;
        end else begin
            state   <= state_n;
            victim  <= victim_n;
            way_cnt <= way_n;
            set_cnt <= set_n;
        end
    end

    always_comb begin
        state_n  = state;
        victim_n = victim;
        way_n    = way_cnt;
        set_n    = set_cnt;
        case (state)
            PROCESS: begin
                if (req_valid) begin
                    if (!hit_any) begin
                        victim_n = victim_c;
                        state_n  = (valid[victim_c] && dirty[victim_c]) ? WRITE_BACK : FETCH;
                    end
                end else if (flush_req) begin
                    state_n = FLUSH_SCAN;
                    way_n   = '0;
                    set_n   = '0;
                end
            end
            WRITE_BACK: if (pmem_resp) state_n = FETCH;
            FETCH:      if (pmem_resp) state_n = PROCESS;
            FLUSH_SCAN: begin
                if (flush_line_dirty) begin
                    state_n = FLUSH_WB;
                end else begin
                    way_n = way_cnt + 1'b1;
                    if (way_cnt == WB'(WAYS - 1)) set_n = set_cnt + 1'b1;
                    if (flush_last) state_n = PROCESS;
                end
            end
            FLUSH_WB: begin
                if (pmem_resp) begin
                    way_n = way_cnt + 1'b1;
                    if (way_cnt == WB'(WAYS - 1)) set_n = set_cnt + 1'b1;
                    state_n = flush_last ? PROCESS : FLUSH_SCAN;
                end
            end
            default: state_n = PROCESS;
        endcase
    end

    always_comb begin
        mem_resp      = 1'b0;
        lru_out       = lru_in;
        load_lru      = 1'b0;
        load_tag      = '0;
        load_data     = '0;
        load_valid    = '0;
        load_dirty    = '0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        data_sel      = 1'b0;
        way_sel       = victim;
        pmem_addr_sel = 1'b0;
        set_override  = 1'b0;
        flush_set     = set_cnt;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        flush_done    = 1'b0;
        case (state)
            PROCESS: begin
                if (req_valid && hit_any) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_out  = plru_update(lru_in, hit_way);
                    if (mem_write) begin
                        load_dirty = WAYS'(1) << hit_way;
                        load_data  = WAYS'(1) << hit_way;
                        dirty_in   = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_tag   = WAYS'(1) << victim;
                    load_data  = WAYS'(1) << victim;
                    load_valid = WAYS'(1) << victim;
                    load_dirty = WAYS'(1) << victim;
                    data_sel   = 1'b1;
                    valid_in   = 1'b1;
                end
            end
            FLUSH_SCAN: begin
                set_override = 1'b1;
                way_sel      = way_cnt;
                if (!flush_line_dirty && flush_last) flush_done = 1'b1;
            end
            FLUSH_WB: begin
                set_override  = 1'b1;
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = way_cnt;
                if (pmem_resp) begin
                    load_dirty = WAYS'(1) << way_cnt;
                    if (flush_last) flush_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
